// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU operation classes,
// immediate formats and the control bundle carried into execute.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_IALU   = 2'b11;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       aluSrc;
        logic       branch;
        logic       jump;
        logic [1:0] aluOp;
    } ctrl_t;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        case (opcode)
            OP_IALU, OP_LOAD, OP_JALR: return IMM_I;
            OP_STORE:                  return IMM_S;
            OP_BRANCH:                 return IMM_B;
            OP_LUI, OP_AUIPC:          return IMM_U;
            OP_JAL:                    return IMM_J;
            default:                   return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake: fetch offers an instruction, decode answers
// with id_ready when it takes it.
interface decode_stage_if #(parameter int XLEN = 32);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;

    modport master (output if_valid, if_instr, if_pc, input id_ready);
    modport slave  (input if_valid, if_instr, if_pc, output id_ready);
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: picks the RV32I immediate format from the opcode and
// returns it sign-extended; formats without an immediate yield zero.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    // Assemble the immediate for the decoded format.
    always_comb begin
        imm = '0;
        case (imm_type_of(instr[6:0]))
            IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_J:   imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: IF/ID register, RV32I field/control decode,
// load-use interlock, back-pressure and branch flush, ID/EX register.
// Build option: DECODE_WB_BYPASS_EN forwards a same-cycle writeback into the
// captured operand values; without it the regfile data is taken as-is.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_stage_if.slave         fetch,
    input  logic                  flush,
    output logic [REG_ADDR_W-1:0] read_1,
    output logic [REG_ADDR_W-1:0] read_2,
    input  logic [XLEN-1:0]       data_1,
    input  logic [XLEN-1:0]       data_2,
    input  logic                  wb_regWrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_val,
    output logic [XLEN-1:0]       ex_rs2_val,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [2:0]            ex_funct3,
    output logic                  ex_funct7_5,
    output logic                  ex_regWrite,
    output logic                  ex_memRead,
    output logic                  ex_memWrite,
    output logic                  ex_aluSrc,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [1:0]            ex_aluOp
);

    logic                  id_valid;
    logic [31:0]           id_instr;
    logic [XLEN-1:0]       id_pc;
    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs2_used;
    ctrl_t                 ctrl;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic                  hazard;
    logic                  ex_adv;
    logic                  id_advance;

    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    // LUI carries immediate bits in the rs1 field; it reads no register.
    assign rs1    = (opcode == OP_LUI) ? '0 : id_instr[19:15];
    assign rs2    = id_instr[24:20];

    assign read_1 = id_valid ? rs1 : '0;
    assign read_2 = id_valid ? rs2 : '0;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (id_instr),
        .imm   (imm)
    );

    // Control bits per opcode; unknown opcodes fall through as a NOP.
    always_comb begin
        ctrl     = '0;
        rs2_used = 1'b0;
        case (opcode)
            OP_R:      begin ctrl.regWrite = 1'b1; ctrl.aluOp = ALUOP_RTYPE; rs2_used = 1'b1; end
            OP_IALU:   begin ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.aluOp = ALUOP_IALU; end
            OP_LOAD:   begin ctrl.regWrite = 1'b1; ctrl.memRead = 1'b1; ctrl.aluSrc = 1'b1; end
            OP_STORE:  begin ctrl.memWrite = 1'b1; ctrl.aluSrc = 1'b1; rs2_used = 1'b1; end
            OP_BRANCH: begin ctrl.branch = 1'b1; ctrl.aluOp = ALUOP_BRANCH; rs2_used = 1'b1; end
            OP_LUI,
            OP_AUIPC:  begin ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; end
            OP_JAL,
            OP_JALR:   begin ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.jump = 1'b1; end
            default:   ctrl = '0;
        endcase
        if (rd == '0) ctrl.regWrite = 1'b0;
    end

`ifdef DECODE_WB_BYPASS_EN
    assign rs1_val = (wb_regWrite && wb_rd != '0 && wb_rd == rs1) ? wb_data : data_1;
    assign rs2_val = (wb_regWrite && wb_rd != '0 && wb_rd == rs2) ? wb_data : data_2;
`else
    logic wb_unused;
    assign wb_unused = ^{wb_regWrite, wb_rd, wb_data};
    assign rs1_val   = data_1;
    assign rs2_val   = data_2;
`endif

    assign hazard = id_valid && ex_valid && ex_memRead && (ex_rd != '0) &&
                    ((ex_rd == rs1) || (rs2_used && ex_rd == rs2));
    assign ex_adv     = ex_ready || !ex_valid;
    assign id_advance = id_valid && !hazard && ex_adv;
    assign fetch.id_ready = !rst && !flush && (!id_valid || id_advance);

    // IF/ID register: flush empties it, otherwise it refills whenever it may accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (fetch.id_ready) begin
            id_valid <= fetch.if_valid;
            if (fetch.if_valid) begin
                id_instr <= fetch.if_instr;
                id_pc    <= fetch.if_pc;
            end
        end
    end

    // ID/EX register: bubble when advancing without a live instruction, hold under back-pressure.
    always_ff @(posedge clk) begin
        if (rst || (ex_adv && (flush || !id_advance))) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7_5 <= 1'b0;
            {ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_branch, ex_jump, ex_aluOp} <= '0;
        end else if (ex_adv) begin
            ex_valid    <= 1'b1;
            ex_pc       <= id_pc;
            ex_rs1_val  <= rs1_val;
            ex_rs2_val  <= rs2_val;
            ex_imm      <= imm;
            ex_rs1      <= rs1;
            ex_rs2      <= rs2;
            ex_rd       <= rd;
            ex_funct3   <= id_instr[14:12];
            ex_funct7_5 <= id_instr[30];
            {ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_branch, ex_jump, ex_aluOp} <= ctrl;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed checks for reset, latency, load-use
// interlock, back-pressure, flush and writeback bypass, then randomized
// traffic checked by an in-order scoreboard against an RV32I reference model.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f75;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        as;
        logic        br;
        logic        jp;
        logic [1:0]  aop;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [4:0]  read_1, read_2;
    logic [31:0] data_1, data_2;
    logic        wb_regWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_5, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_branch, ex_jump;
    logic [1:0]  ex_aluOp;

    logic [31:0] regs [32];
    exp_t        q[$];
    exp_t        act_b;
    int          total = 0;
    int          bad = 0;
    logic        acc_last = 1'b0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) fif ();

    decode_stage dut (
        .clk(clk), .rst(rst), .fetch(fif), .flush(flush),
        .read_1(read_1), .read_2(read_2), .data_1(data_1), .data_2(data_2),
        .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7_5(ex_funct7_5), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .ex_aluSrc(ex_aluSrc), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_aluOp(ex_aluOp)
    );

    assign data_1 = regs[read_1];
    assign data_2 = regs[read_2];
    assign act_b  = {ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3,
                     ex_funct7_5, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_branch,
                     ex_jump, ex_aluOp};

    // Reference decode, written from the ISA encoding with shifts and masks.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic wbw, input logic [4:0] wrd, input logic [31:0] wdat);
        exp_t        e;
        logic [31:0] sx;
        sx = 32'($signed(ins) >>> 31);
        e = '0;
        e.pc  = pc;
        e.rd  = ins[11:7];
        e.f3  = ins[14:12];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.f75 = ins[30];
        case (ins[6:0])
            7'h33: begin e.rw = 1; e.aop = 2'd2; end
            7'h13: begin e.rw = 1; e.as = 1; e.aop = 2'd3; e.imm = 32'($signed(ins) >>> 20); end
            7'h03: begin e.rw = 1; e.mr = 1; e.as = 1; e.imm = 32'($signed(ins) >>> 20); end
            7'h23: begin e.mw = 1; e.as = 1;
                         e.imm = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]); end
            7'h63: begin e.br = 1; e.aop = 2'd1;
                         e.imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1); end
            7'h37: begin e.rw = 1; e.as = 1; e.imm = ins & 32'hFFFF_F000; e.rs1 = 0; end
            7'h17: begin e.rw = 1; e.as = 1; e.imm = ins & 32'hFFFF_F000; end
            7'h6F: begin e.rw = 1; e.as = 1; e.jp = 1;
                         e.imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1); end
            7'h67: begin e.rw = 1; e.as = 1; e.jp = 1; e.imm = 32'($signed(ins) >>> 20); end
            default: ;
        endcase
        if (e.rd == 0) e.rw = 0;
        e.rs1v = regs[e.rs1];
        e.rs2v = regs[e.rs2];
`ifdef DECODE_WB_BYPASS_EN
        if (wbw && wrd != 0 && wrd == e.rs1) e.rs1v = wdat;
        if (wbw && wrd != 0 && wrd == e.rs2) e.rs2v = wdat;
`endif
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        logic ok;
        ok = 1'b0;
        fif.if_valid = 1'b1;
        fif.if_instr = ins;
        fif.if_pc    = pc;
        for (int t = 0; t < 20 && !ok; t++) begin
            #2;
            ok = fif.id_ready;
            step();
        end
        fif.if_valid = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic drain();
        ex_ready = 1'b1;
        fif.if_valid = 1'b0;
        flush = 1'b0;
        for (int t = 0; t < 20 && q.size() != 0; t++) step();
        step();
        step();
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic pair(input string nm, input logic [31:0] i1, input logic [31:0] i2, input int expb);
        int b;
        b = 0;
        send(i1, 32'h500);
        send(i2, 32'h504);
        #1;
        chk({nm, "_id_ready"}, fif.id_ready, expb == 0);
        for (int t = 0; t < 6; t++) begin
            step();
            if (ex_valid) break;
            b++;
        end
        chk({nm, "_bubbles"}, b, expb);
    endtask

    // Monitor/scoreboard: compares every transfer into execute, checks hold under
    // back-pressure, and records accepted or flushed instructions.
    initial begin
        exp_t snap;
        exp_t e;
        logic stalled;
        stalled = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stalled) begin
                    total++;
                    if (act_b !== snap) begin
                        bad++;
                        $display("FAIL hold: got %h expected %h", act_b, snap);
                    end
                end
                stalled = ex_valid && !ex_ready;
                snap = act_b;
                if (ex_valid && ex_ready) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_output: got %h expected nothing", act_b);
                    end else begin
                        e = q.pop_front();
                        if (act_b !== e) begin
                            bad++;
                            $display("FAIL ex_bundle: got %h expected %h", act_b, e);
                        end
                    end
                end
                if (flush) begin
                    if (q.size() != 0) void'(q.pop_back());
                    acc_last = 1'b0;
                end else begin
                    acc_last = fif.if_valid && fif.id_ready;
                    if (acc_last) q.push_back(model(fif.if_instr, fif.if_pc, wb_regWrite, wb_rd, wb_data));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cur;
        logic [31:0] pc;
        logic [31:0] exp_byp;
        logic        have;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
        regs[5] = 32'h1234_5678;
        fif.if_valid = 1'b0; fif.if_instr = '0; fif.if_pc = '0;
        flush = 1'b0; wb_regWrite = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_id_ready", fif.id_ready, 0);
        chk("rst_ex_zero", {31'b0, |act_b}, 0);
        chk("rst_read_1", read_1, 0);
        rst = 1'b0;
        #2;
        chk("id_ready_after_rst", fif.id_ready, 1);
        step();

        send(32'h00F0_0293, 32'h100);
        chk("addi_read_1", read_1, 0);
        step();
        chk("addi_ex_valid", ex_valid, 1);
        chk("addi_ex_pc", ex_pc, 32'h100);
        chk("addi_ex_rd", ex_rd, 5);
        chk("addi_ex_imm", ex_imm, 15);
        chk("addi_ex_aluOp", ex_aluOp, 2'b11);
        chk("addi_ex_aluSrc", ex_aluSrc, 1);
        chk("addi_ex_regWrite", ex_regWrite, 1);
        drain();

        pair("lw_add", 32'h0000_A383, 32'h0023_8433, 1);
        chk("lw_add_ex_rs1", ex_rs1, 7);
        chk("lw_add_ex_rs2", ex_rs2, 2);
        chk("lw_add_ex_aluOp", ex_aluOp, 2'b10);
        drain();
        pair("lw_addi", 32'h0000_A383, 32'h0071_0493, 0);
        drain();
        pair("lw_sw", 32'h0000_A383, 32'h0071_A023, 1);
        drain();
        pair("lw_x0", 32'h0000_A003, 32'h0020_0433, 0);
        drain();

        ex_ready = 1'b0;
        send(32'h00F0_0293, 32'h200);
        send(32'h0023_8433, 32'h204);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_id_ready", fif.id_ready, 0);
            chk("bp_ex_pc", ex_pc, 32'h200);
            step();
        end
        ex_ready = 1'b1;
        step();
        chk("bp_resume_pc", ex_pc, 32'h204);
        chk("bp_resume_valid", ex_valid, 1);
        drain();

        send(32'h0023_8433, 32'h300);
        chk("flush_read_1", read_1, 7);
        chk("flush_read_2", read_2, 2);
        flush = 1'b1;
        #1;
        chk("flush_id_ready", fif.id_ready, 0);
        step();
        flush = 1'b0;
        chk("flush_ex_valid", ex_valid, 0);
        chk("flush_read_1_empty", read_1, 0);
        drain();

        wb_regWrite = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_DEAD;
`ifdef DECODE_WB_BYPASS_EN
        exp_byp = 32'h0000_DEAD;
`else
        exp_byp = regs[5];
`endif
        send(32'h0012_8313, 32'h400);
        step();
        chk("bypass_rs1_val", ex_rs1_val, exp_byp);
        drain();
        wb_regWrite = 1'b0; wb_rd = '0; wb_data = '0;

        pc = 32'h1000;
        cur = '0;
        have = 1'b0;
        for (int c = 0; c < 800; c++) begin
            ex_ready = ($urandom_range(0, 3) != 0);
            if (acc_last && $urandom_range(0, 7) == 0) begin
                flush = 1'b1;
                fif.if_valid = 1'b0;
                have = 1'b0;
            end else begin
                flush = 1'b0;
                if (acc_last || !have) begin
                    have = ($urandom_range(0, 3) != 0);
                    if (have) begin
                        cur = rand_instr();
                        pc = pc + 4;
                    end
                end
                fif.if_valid = have;
                fif.if_instr = cur;
                fif.if_pc    = pc;
            end
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
